// File: rtl/dt_engine_param.sv
// dt_engine_param: two-pass chessboard / city-block distance transform over a packed
// binary image, with a start/busy/done handshake so it can be re-run without reset.
module dt_engine_param #(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int STI_W  = 16,
  parameter int PIX_W  = 8,
  parameter int METRIC = 0,
  localparam int SA = $clog2(IMG_W*IMG_H/STI_W),
  localparam int RA = $clog2(IMG_W*IMG_H)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             fwpass_finish,
  output logic             done,
  output logic             sti_rd,
  output logic [SA-1:0]    sti_addr,
  input  logic [STI_W-1:0] sti_di,
  output logic             res_rd,
  output logic             res_wr,
  output logic [RA-1:0]    res_addr,
  output logic [PIX_W-1:0] res_do,
  input  logic [PIX_W-1:0] res_di
);
  localparam int CW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int BCW = (STI_W > 1) ? $clog2(STI_W) : 1;
  localparam logic [RA-1:0]    ONE_A    = RA'(1);
  localparam logic [RA-1:0]    W_A      = RA'(IMG_W);
  localparam logic [RA-1:0]    LAST_PIX = RA'(IMG_W*IMG_H-1);
  localparam logic [CW-1:0]    COL_MAX  = CW'(IMG_W-1);
  localparam logic [RW-1:0]    ROW_MAX  = RW'(IMG_H-1);
  localparam logic [BCW-1:0]   BC_MAX   = BCW'(STI_W-1);
  localparam logic [PIX_W-1:0] PMAX     = {PIX_W{1'b1}};
  localparam logic [2:0]       FW_LAST  = (METRIC == 1) ? 3'd1 : 3'd3;
  localparam logic [2:0]       BW_LAST  = (METRIC == 1) ? 3'd2 : 3'd4;
  localparam logic [3:0] K_SELF = 4'd0, K_NW = 4'd1, K_N = 4'd2, K_NE = 4'd3, K_W = 4'd4,
                         K_E = 4'd5, K_SW = 4'd6, K_S = 4'd7, K_SE = 4'd8;

  typedef enum logic [2:0] {S_IDLE, S_FW_STI, S_FW_RD, S_FW_WR, S_FW_END,
                            S_BW_RD, S_BW_WR, S_DONE} state_t;

  state_t state_q, state_d;
  logic [RA-1:0] pix_q, pix_d, res_addr_q, res_addr_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [BCW-1:0] bcnt_q, bcnt_d;
  logic [SA-1:0] wrd_q, wrd_d, sti_addr_q, sti_addr_d;
  logic [STI_W-1:0] sreg_q, sreg_d;
  logic [2:0] nb_q, nb_d;
  logic [PIX_W-1:0] min_q, min_d, self_q, self_d, res_do_q, res_do_d;
  logic busy_q, busy_d, done_q, done_d, fwfin_q, fwfin_d;
  logic sti_rd_q, sti_rd_d, res_rd_q, res_rd_d, res_wr_q, res_wr_d;

  logic is_bw_s, use_cur_s, l_bit_s, fw_go_s, bw_go_s, finish_s;
  logic [RA-1:0] fw_pix_s, bw_pix_s, l_pix_s;
  logic [RW-1:0] fw_row_s, bw_row_s, l_row_s;
  logic [CW-1:0] fw_col_s, bw_col_s, l_col_s;
  logic [RA:0] l0_s, nx_s, cur_s;
  logic [PIX_W-1:0] nb_val_s, nb_min_s;

  // Neighbour visiting order per pass; index 0 of the backward pass is the pixel itself.
  function automatic logic [3:0] kind_of(input logic bw, input logic [2:0] idx);
    logic [3:0] k;
    k = K_SELF;
    if (!bw) begin
      if (METRIC == 1) k = (idx == 3'd0) ? K_N : K_W;
      else begin
        case (idx)
          3'd0:    k = K_NW;
          3'd1:    k = K_N;
          3'd2:    k = K_NE;
          default: k = K_W;
        endcase
      end
    end else if (METRIC == 1) begin
      case (idx)
        3'd0:    k = K_SELF;
        3'd1:    k = K_E;
        default: k = K_S;
      endcase
    end else begin
      case (idx)
        3'd0:    k = K_SELF;
        3'd1:    k = K_E;
        3'd2:    k = K_SW;
        3'd3:    k = K_S;
        default: k = K_SE;
      endcase
    end
    return k;
  endfunction

  // Returns {inside_image, address}; outside neighbours are never read and count as 0.
  function automatic logic [RA:0] nb_loc(input logic [3:0] k, input logic [RA-1:0] p,
                                         input logic [RW-1:0] r, input logic [CW-1:0] c);
    logic ok;
    logic [RA-1:0] a;
    case (k)
      K_NW:    begin ok = (r != '0) && (c != '0);           a = p - W_A - ONE_A; end
      K_N:     begin ok = (r != '0);                        a = p - W_A;         end
      K_NE:    begin ok = (r != '0) && (c != COL_MAX);      a = p - W_A + ONE_A; end
      K_W:     begin ok = (c != '0);                        a = p - ONE_A;       end
      K_E:     begin ok = (c != COL_MAX);                   a = p + ONE_A;       end
      K_SW:    begin ok = (r != ROW_MAX) && (c != '0);      a = p + W_A - ONE_A; end
      K_S:     begin ok = (r != ROW_MAX);                   a = p + W_A;         end
      K_SE:    begin ok = (r != ROW_MAX) && (c != COL_MAX); a = p + W_A + ONE_A; end
      default: begin ok = 1'b1;                             a = p;               end
    endcase
    return {ok, a};
  endfunction

  function automatic logic [PIX_W-1:0] sat_inc(input logic [PIX_W-1:0] x);
    return (x == PMAX) ? PMAX : x + PIX_W'(1);
  endfunction

  function automatic logic [PIX_W-1:0] min2(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  // Pixel stepping and neighbour address datapath.
  always_comb begin
    is_bw_s   = (state_q == S_BW_RD) || (state_q == S_BW_WR) || (state_q == S_FW_END);
    use_cur_s = (state_q == S_FW_STI) || (state_q == S_FW_END);
    fw_pix_s  = pix_q + ONE_A;
    fw_col_s  = (col_q == COL_MAX) ? '0 : col_q + CW'(1);
    fw_row_s  = (col_q == COL_MAX) ? row_q + RW'(1) : row_q;
    bw_pix_s  = pix_q - ONE_A;
    bw_col_s  = (col_q == '0) ? COL_MAX : col_q - CW'(1);
    bw_row_s  = (col_q == '0) ? row_q - RW'(1) : row_q;
    l_pix_s   = use_cur_s ? pix_q : (is_bw_s ? bw_pix_s : fw_pix_s);
    l_row_s   = use_cur_s ? row_q : (is_bw_s ? bw_row_s : fw_row_s);
    l_col_s   = use_cur_s ? col_q : (is_bw_s ? bw_col_s : fw_col_s);
    l_bit_s   = (state_q == S_FW_STI) ? sti_di[STI_W-1] : sreg_q[STI_W-2];
    l0_s      = nb_loc(kind_of(is_bw_s, 3'd0), l_pix_s, l_row_s, l_col_s);
    nx_s      = nb_loc(kind_of(is_bw_s, nb_q + 3'd1), pix_q, row_q, col_q);
    cur_s     = nb_loc(kind_of(is_bw_s, nb_q), pix_q, row_q, col_q);
    nb_val_s  = cur_s[RA] ? res_di : '0;
    nb_min_s  = min2(nb_val_s, min_q);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q; pix_d = pix_q; row_d = row_q; col_d = col_q;
    bcnt_d = bcnt_q; wrd_d = wrd_q; sreg_d = sreg_q;
    nb_d = nb_q; min_d = min_q; self_d = self_q;
    busy_d = busy_q; done_d = done_q; fwfin_d = 1'b0;
    sti_rd_d = 1'b0; sti_addr_d = sti_addr_q;
    res_rd_d = 1'b0; res_wr_d = 1'b0; res_addr_d = res_addr_q; res_do_d = res_do_q;
    fw_go_s = 1'b0; bw_go_s = 1'b0; finish_s = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_FW_STI; busy_d = 1'b1; done_d = 1'b0;
          pix_d = '0; row_d = '0; col_d = '0; wrd_d = '0;
          sti_rd_d = 1'b1; sti_addr_d = '0;
        end else begin
          state_d = state_q;
        end
      end
      S_FW_STI: begin
        sreg_d = sti_di; bcnt_d = '0; wrd_d = wrd_q + SA'(1); fw_go_s = 1'b1;
      end
      S_FW_RD: begin
        if (nb_q == FW_LAST) begin
          state_d = S_FW_WR; res_wr_d = 1'b1; res_addr_d = pix_q; res_do_d = sat_inc(nb_min_s);
        end else begin
          nb_d = nb_q + 3'd1; min_d = nb_min_s; res_rd_d = nx_s[RA]; res_addr_d = nx_s[RA-1:0];
        end
      end
      S_FW_WR: begin
        if (pix_q == LAST_PIX) begin
          state_d = S_FW_END; fwfin_d = 1'b1;
        end else begin
          pix_d = fw_pix_s; row_d = fw_row_s; col_d = fw_col_s;
          if (bcnt_q == BC_MAX) begin
            state_d = S_FW_STI; sti_rd_d = 1'b1; sti_addr_d = wrd_q;
          end else begin
            bcnt_d = bcnt_q + BCW'(1); sreg_d = {sreg_q[STI_W-2:0], 1'b0}; fw_go_s = 1'b1;
          end
        end
      end
      S_FW_END: bw_go_s = 1'b1;
      S_BW_RD: begin
        if (nb_q == 3'd0) begin
          if (res_di == '0) finish_s = 1'b1;
          else begin
            self_d = res_di; nb_d = 3'd1; res_rd_d = nx_s[RA]; res_addr_d = nx_s[RA-1:0];
          end
        end else if (nb_q == BW_LAST) begin
          state_d = S_BW_WR; res_wr_d = 1'b1; res_addr_d = pix_q;
          res_do_d = min2(self_q, sat_inc(nb_min_s));
        end else begin
          nb_d = nb_q + 3'd1; min_d = nb_min_s; res_rd_d = nx_s[RA]; res_addr_d = nx_s[RA-1:0];
        end
      end
      S_BW_WR: finish_s = 1'b1;
      default: state_d = S_IDLE;
    endcase
    // Backward pass steps towards pixel 0; leaving pixel 0 completes the run.
    if (finish_s) begin
      if (pix_q == '0) begin
        state_d = S_DONE; done_d = 1'b1; busy_d = 1'b0;
      end else begin
        pix_d = bw_pix_s; row_d = bw_row_s; col_d = bw_col_s; bw_go_s = 1'b1;
      end
    end else begin
      finish_s = 1'b0;
    end
    if (fw_go_s) begin
      nb_d = 3'd0; min_d = PMAX;
      if (l_bit_s) begin
        state_d = S_FW_RD; res_rd_d = l0_s[RA]; res_addr_d = l0_s[RA-1:0];
      end else begin
        state_d = S_FW_WR; res_wr_d = 1'b1; res_addr_d = l_pix_s; res_do_d = '0;
      end
    end else if (bw_go_s) begin
      state_d = S_BW_RD; nb_d = 3'd0; min_d = PMAX; res_rd_d = 1'b1; res_addr_d = l_pix_s;
    end else begin
      fw_go_s = 1'b0;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE; pix_q <= '0; row_q <= '0; col_q <= '0; bcnt_q <= '0; wrd_q <= '0;
      sreg_q <= '0; nb_q <= '0; min_q <= '0; self_q <= '0;
      busy_q <= 1'b0; done_q <= 1'b0; fwfin_q <= 1'b0; sti_rd_q <= 1'b0; sti_addr_q <= '0;
      res_rd_q <= 1'b0; res_wr_q <= 1'b0; res_addr_q <= '0; res_do_q <= '0;
    end else begin
      state_q <= state_d; pix_q <= pix_d; row_q <= row_d; col_q <= col_d; bcnt_q <= bcnt_d;
      wrd_q <= wrd_d; sreg_q <= sreg_d; nb_q <= nb_d; min_q <= min_d; self_q <= self_d;
      busy_q <= busy_d; done_q <= done_d; fwfin_q <= fwfin_d; sti_rd_q <= sti_rd_d;
      sti_addr_q <= sti_addr_d; res_rd_q <= res_rd_d; res_wr_q <= res_wr_d;
      res_addr_q <= res_addr_d; res_do_q <= res_do_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign fwpass_finish = fwfin_q;
  assign sti_rd = sti_rd_q;
  assign sti_addr = sti_addr_q;
  assign res_rd = res_rd_q;
  assign res_wr = res_wr_q;
  assign res_addr = res_addr_q;
  assign res_do = res_do_q;
endmodule

// File: tb/tb_dt_engine_param.sv
// tb_dt_engine_param: runs a chessboard and a city-block engine side by side on random and
// directed images and compares every result word with a brute-force nearest-background model.
`timescale 1ns/1ps
module tb_dt_engine_param;
  localparam int W = 24, H = 10, SW = 8, PW = 2;
  localparam int NP = W*H, NW = NP/SW;
  localparam int SA = $clog2(NW), RA = $clog2(NP);
  localparam int PMAX = (1 << PW) - 1;
  localparam int BUDGET = 14*NP + 64;

  logic clk = 1'b0;
  logic reset;
  logic [1:0] start, busy, fwf, done, sti_rd, res_rd, res_wr;
  logic [SA-1:0] sti_addr [2];
  logic [SW-1:0] sti_di [2];
  logic [RA-1:0] res_addr [2];
  logic [PW-1:0] res_do [2];
  logic [PW-1:0] res_di [2];
  logic [SW-1:0] rom [NW];
  logic [PW-1:0] ram [2][NP];
  logic scrub;
  bit img [NP];
  int total, bad;

  always #5 clk = ~clk;

  dt_engine_param #(.IMG_W(W), .IMG_H(H), .STI_W(SW), .PIX_W(PW), .METRIC(0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start[0]), .busy(busy[0]), .fwpass_finish(fwf[0]),
    .done(done[0]), .sti_rd(sti_rd[0]), .sti_addr(sti_addr[0]), .sti_di(sti_di[0]),
    .res_rd(res_rd[0]), .res_wr(res_wr[0]), .res_addr(res_addr[0]), .res_do(res_do[0]),
    .res_di(res_di[0]));

  dt_engine_param #(.IMG_W(W), .IMG_H(H), .STI_W(SW), .PIX_W(PW), .METRIC(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start[1]), .busy(busy[1]), .fwpass_finish(fwf[1]),
    .done(done[1]), .sti_rd(sti_rd[1]), .sti_addr(sti_addr[1]), .sti_di(sti_di[1]),
    .res_rd(res_rd[1]), .res_wr(res_wr[1]), .res_addr(res_addr[1]), .res_do(res_do[1]),
    .res_di(res_di[1]));

  assign sti_di[0] = rom[sti_addr[0]];
  assign sti_di[1] = rom[sti_addr[1]];
  assign res_di[0] = ram[0][res_addr[0]];
  assign res_di[1] = ram[1][res_addr[1]];

  // Result RAMs; scrub fills them with garbage so stale contents cannot hide a missing write.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (scrub) begin
        for (int p = 0; p < NP; p++) ram[d][p] <= PW'($urandom);
      end else if (res_wr[d]) begin
        ram[d][res_addr[d]] <= res_do[d];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Distance to the nearest background pixel; the ring just outside the image is background.
  function automatic int ref_dist(int p, int metric);
    int r, c, best, dr, dc, dd;
    if (!img[p]) return 0;
    r = p / W; c = p % W;
    best = r + 1;
    if (c + 1 < best) best = c + 1;
    if (H - r < best) best = H - r;
    if (W - c < best) best = W - c;
    for (int q = 0; q < NP; q++) begin
      if (!img[q]) begin
        dr = (q / W > r) ? q / W - r : r - q / W;
        dc = (q % W > c) ? q % W - c : c - q % W;
        dd = (metric == 1) ? dr + dc : ((dr > dc) ? dr : dc);
        if (dd < best) best = dd;
      end
    end
    return (best > PMAX) ? PMAX : best;
  endfunction

  task automatic chk_quiet(input string tag);
    check({tag, ":busy"}, 32'(busy), 32'd0);
    check({tag, ":done"}, 32'(done), 32'd0);
    check({tag, ":fwfin"}, 32'(fwf), 32'd0);
    check({tag, ":sti_rd"}, 32'(sti_rd), 32'd0);
    check({tag, ":res_rd_wr"}, 32'({res_rd, res_wr}), 32'd0);
    check({tag, ":addr0"}, 32'({res_addr[0], sti_addr[0], res_do[0]}), 32'd0);
  endtask

  task automatic fill(input int dens);
    for (int p = 0; p < NP; p++) img[p] = ($urandom_range(0, 99) < dens);
  endtask

  task automatic run(input string name, input bit poke);
    int cyc, viol;
    int fcnt [2];
    int fat [2];
    for (int w = 0; w < NW; w++)
      for (int k = 0; k < SW; k++) rom[w][SW-1-k] = img[w*SW+k];
    @(negedge clk); scrub = 1'b1;
    @(negedge clk); scrub = 1'b0; start = 2'b11;
    @(negedge clk); start = 2'b00;
    check({name, ":busy_on"}, 32'({busy, done}), 32'b1100);
    cyc = 0; viol = 0; fcnt = '{0, 0}; fat = '{-1, -1};
    while (!(done[0] && done[1]) && cyc < BUDGET) begin
      for (int d = 0; d < 2; d++) start[d] = poke && (cyc == 10 || cyc == fat[d]);
      @(negedge clk); cyc++;
      for (int d = 0; d < 2; d++) begin
        if (fwf[d]) begin fcnt[d]++; fat[d] = cyc + 2; end
        if ((res_rd[d] && res_wr[d]) || (busy[d] && done[d]) || (fwf[d] && done[d]) ||
            (res_wr[d] && int'(res_addr[d]) >= NP)) viol++;
      end
    end
    start = 2'b00;
    check({name, ":in_time"}, 32'(cyc < BUDGET), 32'd1);
    check({name, ":fwfin0"}, 32'(fcnt[0]), 32'd1);
    check({name, ":fwfin1"}, 32'(fcnt[1]), 32'd1);
    check({name, ":protocol"}, 32'(viol), 32'd0);
    repeat (2) @(negedge clk);
    check({name, ":done_held"}, 32'({busy, done}), 32'b0011);
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < NP; p++)
        check($sformatf("%s:m%0d[%0d]", name, d, p), 32'(ram[d][p]), 32'(ref_dist(p, d)));
  endtask

  initial begin
    total = 0; bad = 0; reset = 1'b0; start = 2'b00; scrub = 1'b0;
    for (int p = 0; p < NP; p++) img[p] = 1'b0;
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    reset = 1'b1;
    @(negedge clk);

    img[5*W+5] = 1'b1;
    run("single", 1'b0);
    for (int p = 0; p < NP; p++) img[p] = (p / W >= 2 && p / W <= 6 && p % W >= 10 && p % W <= 14);
    run("square", 1'b1);
    for (int p = 0; p < NP; p++) img[p] = 1'b0;
    run("empty", 1'b0);
    for (int p = 0; p < NP; p++) img[p] = (p < W);
    run("row0", 1'b0);
    for (int p = 0; p < NP; p++) img[p] = 1'b1;
    run("full", 1'b1);
    fill(30); run("rand30", 1'b1);
    fill(60); run("rand60", 1'b0);
    fill(85); run("rand85", 1'b1);
    fill(95); run("rand95", 1'b0);

    // abort a run part-way through the forward pass
    @(negedge clk); start = 2'b11;
    @(negedge clk); start = 2'b00;
    repeat (40) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_quiet("mid_reset");
    reset = 1'b1;
    fill(70); run("after_reset", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
